// File: rtl/pipe_add.sv
// pipe_add: pipelined ripple-carry adder with a valid/ready handshake.
// Operands are cut into STAGES slices of SW = WIDTH/STAGES bits; stage k adds
// slice k plus the carry registered by stage k-1. Unconsumed operand bits ride
// along in shrinking delay registers and finished sum slices accumulate in
// growing registers, so the full sum leaves the last stage already aligned.
// Optional feature: define PIPE_ADD_SUB_EN to add a 'sub' port (a - b).
module pipe_add #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Effective operand B and carry-in; subtraction is folded in at entry so the
  // inverted B travels down the pipe with its own transaction.
  always_comb begin
`ifdef PIPE_ADD_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = sub | cin;
`else
    b_eff   = b;
    cin_eff = cin;
`endif
  end

  // One global enable: the whole pipe advances only when the output slot is
  // empty or being drained this cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added on entry to / exit from this stage.
    localparam int REM = WIDTH - (k + 1) * SW;

    logic [REM+SW-1:0]     a_src;
    logic [REM+SW-1:0]     b_src;
    logic                  c_in;
    logic                  v_in;
    logic [SW:0]           res;
    logic [(k+1)*SW-1:0]   s_nxt;
    logic                  v_q;
    logic                  c_q;
    logic [(k+1)*SW-1:0]   s_q;

    if (k == 0) begin : g_src
      assign a_src = a;
      assign b_src = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = in_valid;
      assign s_nxt = res[SW-1:0];
    end else begin : g_src
      assign a_src = g_stage[k-1].g_rem.a_q;
      assign b_src = g_stage[k-1].g_rem.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_nxt = {res[SW-1:0], g_stage[k-1].s_q};
    end

    // Slice adder: SW-bit ripple add producing SW sum bits plus carry-out.
    always_comb begin
      res = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_in};
    end

    // Stage register: valid, carry and accumulated sum, held while stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        // NOTE: pipeline state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value, independent of block order.
        v_q <= v_in;
        c_q <= res[SW];
        s_q <= s_nxt;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Operand delay line: drop the slice just consumed, keep the rest.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_src[REM+SW-1:SW];
          b_q <= b_src[REM+SW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic c_msb;
      logic ovf_q;

      // Carry into the MSB, recovered from the MSB's own sum equation.
      assign c_msb = a_src[SW-1] ^ b_src[SW-1] ^ res[SW-1];

      // Signed overflow flag registered alongside the final sum.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ res[SW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed, table-driven bench for pipe_add (WIDTH=16).
// Three instances share the input side: STAGES=4 (main), 1 and 16 (latency).
module tb_pipe_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;

  logic        in_ready,   out_valid,   cout,   ovf;
  logic        in_ready1,  out_valid1,  cout1,  ovf1;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum, sum1, sum16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_add #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_add #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  pipe_add #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one transaction for one cycle and wait for the main DUT result.
  task automatic run_one(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic vs, output logic [15:0] s, output logic co,
                         output logic ov, output int lat);
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout; ov = ovf;
    @(negedge clk);
  endtask

  vec_t        vecs[9];
  logic [15:0] rs;
  logic        rco, rov;
  int          lat;

  initial begin
    logic [15:0] ta[8], tbv[8];
    logic        tc[8];
    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic [16:0] full;
    logic [15:0] held;
    int          l1, l4, l16, sent, got, n, t0, t1;
    logic [15:0] s1, s4, s16;
    logic        c1, c4, c16, o1, o4, o16, stale;

    vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset values.
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // Latency of all three configurations on the first scenario.
    @(negedge clk);
    a = 16'h1234; b = 16'h0FED; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1; l1 = 0; l4 = 0; l16 = 0;
    s1 = '0; s4 = '0; s16 = '0; c1 = 0; c4 = 0; c16 = 0; o1 = 0; o4 = 0; o16 = 0;
    while (n <= 40 && (l1 == 0 || l4 == 0 || l16 == 0)) begin
      if (out_valid1 && l1 == 0)   begin l1 = n;  s1 = sum1;   c1 = cout1;   o1 = ovf1;   end
      if (out_valid && l4 == 0)    begin l4 = n;  s4 = sum;    c4 = cout;    o4 = ovf;    end
      if (out_valid16 && l16 == 0) begin l16 = n; s16 = sum16; c16 = cout16; o16 = ovf16; end
      @(negedge clk);
      n++;
    end
    check("lat_s1", l1, 1);
    check("lat_s4", l4, 4);
    check("lat_s16", l16, 16);
    check("lat_s1_res", {o1, c1, s1}, {2'b00, 16'h2221});
    check("lat_s4_res", {o4, c4, s4}, {2'b00, 16'h2221});
    check("lat_s16_res", {o16, c16, s16}, {2'b00, 16'h2221});
    repeat (2) @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 9; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rco, rov, lat);
      check($sformatf("vec%0d_lat", i), lat, 4);
      check($sformatf("vec%0d_sum", i), rs, vecs[i].s);
      check($sformatf("vec%0d_cout", i), rco, vecs[i].co);
      check($sformatf("vec%0d_ovf", i), rov, vecs[i].ov);
    end

`ifdef PIPE_ADD_SUB_EN
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rco, rov, lat);
    check("sub_5m7", {rov, rco, rs}, {2'b00, 16'hFFFE});
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rco, rov, lat);
    check("sub_5m7_cin", {rov, rco, rs}, {2'b00, 16'hFFFE});
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rco, rov, lat);
    check("sub_8000m1", {rov, rco, rs}, {2'b11, 16'h7FFF});
    run_one(16'h1234, 16'h0FED, 1'b1, 1'b0, rs, rco, rov, lat);
    check("sub0_add", {rov, rco, rs}, {2'b00, 16'h2222});
`endif

    // Back-to-back pair: consecutive results.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    t0 = -1; t1 = -1; got = 0;
    for (int c = 2; c < 30 && got < 2; c++) begin
      if (out_valid) begin
        if (got == 0) begin
          t0 = c;
          check("b2b_first", {ovf, cout, sum}, {2'b01, 16'h0000});
        end else begin
          t1 = c;
          check("b2b_second", {ovf, cout, sum}, {2'b10, 16'h8000});
        end
        got++;
      end
      @(negedge clk);
    end
    check("b2b_first_lat", t0, 4);
    check("b2b_consecutive", t1, 5);
    repeat (2) @(negedge clk);

    // Random stream of 8 with out_ready low for cycles 5..7.
    for (int i = 0; i < 8; i++) begin
      ta[i] = 16'($urandom); tbv[i] = 16'($urandom); tc[i] = 1'($urandom);
    end
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        a = ta[sent]; b = tbv[sent]; cin = tc[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        if (c > 5) check("stall_hold", sum, held);
      end
      if (c == 5) held = sum;
      if (in_valid && in_ready) begin
        full = {1'b0, ta[sent]} + {1'b0, tbv[sent]} + {16'b0, tc[sent]};
        e = {(ta[sent][15] == tbv[sent][15]) && (full[15] != ta[sent][15]), full};
        exp_q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stall_extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stall_res%0d", got), {ovf, cout, sum}, e);
          got++;
        end
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    check("stall_count", got, 8);
    check("stall_pending", exp_q.size(), 0);
    repeat (6) @(negedge clk);

    // Reset with 3 transactions in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'(i + 1); b = 16'h0100; cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_flight_valid", out_valid, 0);
    check("rst_flight_sum", sum, 0);
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid || out_valid1 || out_valid16) stale = 1'b1;
    end
    check("rst_no_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
